mem_access_unit: RTL and testbench

- MEM-stage initiator that drives the data-cache/memory request interface: mem_addr, mem_wdata, mem_read, mem_write, mem_mask, with mem_rdata and mem_hit returned.
- Accepts one load/store from the pipeline and checks alignment and mask legality.
- Holds the bus request until mem_hit or timeout, then returns the load data or a fault, with busy/stall and performance counters.
- Sits between the EX/MEM pipeline register and the cache system.

---
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: legality check, held bus request until hit or
// timeout, one-cycle registered response, saturating performance counters.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic             req_read,
  input  logic             req_write,
  input  logic [2:0]       req_mask,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             fault_misaligned,
  output logic             fault_timeout,
  output logic             stall,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       mem_mask,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_hit,
  output logic [CNT_W-1:0] load_count,
  output logic [CNT_W-1:0] store_count,
  output logic [CNT_W-1:0] fault_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, FAULT} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]         mask_q, mask_d;
  logic               rd_q, rd_d, wr_q, wr_d, is_ld_q, is_ld_d;
  logic               fmis_q, fmis_d, ftmo_q, ftmo_d, rv_q, rv_d;
  logic [15:0]        tmo_q, tmo_d;
  logic [CNT_W-1:0]   lcnt_q, lcnt_d, scnt_q, scnt_d, fcnt_q, fcnt_d;
  logic               accept, illegal;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign accept  = req_valid && (state_q == IDLE) && (req_read || req_write);
  assign illegal = (req_read && req_write) ||
                   (req_mask inside {3'b011, 3'b110, 3'b111}) ||
                   (req_write && (req_mask inside {3'b100, 3'b101})) ||
                   ((req_mask inside {3'b001, 3'b101}) && req_addr[0]) ||
                   ((req_mask == 3'b010) && (req_addr[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    is_ld_d = is_ld_q;
    rdata_d = rdata_q;
    fmis_d  = fmis_q;
    ftmo_d  = ftmo_q;
    tmo_d   = tmo_q;
    lcnt_d  = lcnt_q;
    scnt_d  = scnt_q;
    fcnt_d  = fcnt_q;
    rv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal) begin
            // Rejected before any strobe reaches the bus.
            state_d = FAULT;
            fmis_d  = 1'b1;
            ftmo_d  = 1'b0;
            rdata_d = '0;
          end else begin
            state_d = ISSUE;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            mask_d  = req_mask;
            rd_d    = req_read;
            wr_d    = req_write;
            is_ld_d = req_read;
            tmo_d   = '0;
          end
        end
      end
      ISSUE: begin
        if (mem_hit) begin
          rdata_d = rd_q ? mem_rdata : '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          fmis_d  = 1'b0;
          ftmo_d  = 1'b0;
          state_d = RESP;
        end else if (tmo_q == TMO_LAST) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          rdata_d = '0;
          fmis_d  = 1'b0;
          ftmo_d  = 1'b1;
          state_d = FAULT;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      RESP: begin
        rv_d    = 1'b1;
        if (is_ld_q) lcnt_d = sat_inc(lcnt_q);
        else         scnt_d = sat_inc(scnt_q);
        state_d = IDLE;
      end
      FAULT: begin
        rv_d    = 1'b1;
        fcnt_d  = sat_inc(fcnt_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      is_ld_q <= 1'b0;
      rdata_q <= '0;
      fmis_q  <= 1'b0;
      ftmo_q  <= 1'b0;
      rv_q    <= 1'b0;
      tmo_q   <= '0;
      lcnt_q  <= '0;
      scnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      is_ld_q <= is_ld_d;
      rdata_q <= rdata_d;
      fmis_q  <= fmis_d;
      ftmo_q  <= ftmo_d;
      rv_q    <= rv_d;
      tmo_q   <= tmo_d;
      lcnt_q  <= lcnt_d;
      scnt_q  <= scnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign stall            = !req_ready;
  assign resp_valid       = rv_q;
  assign resp_rdata       = rdata_q;
  assign fault_misaligned = fmis_q;
  assign fault_timeout    = ftmo_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign mem_read         = rd_q;
  assign mem_write        = wr_q;
  assign mem_mask         = mask_q;
  assign load_count       = lcnt_q;
  assign store_count      = scnt_q;
  assign fault_count      = fcnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: byte-array memory with programmable hit
// latency, transaction-level expectation model and a per-cycle compare process.
module tb_mem_access_unit;
  localparam int T    = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_mask = '0;
  logic req_ready, resp_valid, fault_misaligned, fault_timeout, stall;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic mem_read, mem_write, mem_hit;
  logic [2:0] mem_mask;
  logic [CW-1:0] load_count, store_count, fault_count;

  mem_access_unit #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_read(req_read),
    .req_write(req_write), .req_mask(req_mask), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .fault_misaligned(fault_misaligned),
    .fault_timeout(fault_timeout), .stall(stall), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_mask(mem_mask), .mem_rdata(mem_rdata), .mem_hit(mem_hit),
    .load_count(load_count), .store_count(store_count), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory environment: placement and sign extension live here, not in the DUT.
  logic [7:0] mem [256];
  int acc = -100, hit_lat = 1;

  function automatic logic [31:0] ld(input logic [31:0] a, input logic [2:0] m);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a[7:0]];
    b1 = mem[8'(a[7:0] + 8'd1)];
    b2 = mem[8'(a[7:0] + 8'd2)];
    b3 = mem[8'(a[7:0] + 8'd3)];
    case (m)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b010:  return {b3, b2, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return 32'h0;
    endcase
  endfunction

  assign mem_rdata = ld(mem_addr, mem_mask);
  assign mem_hit   = (mem_read || mem_write) && (cyc - acc + 1 >= hit_lat);

  always @(negedge clk) begin
    if (!reset && mem_write && mem_hit) begin
      mem[mem_addr[7:0]] <= mem_wdata[7:0];
      if (mem_mask != 3'b000) mem[8'(mem_addr[7:0] + 8'd1)] <= mem_wdata[15:8];
      if (mem_mask == 3'b010) begin
        mem[8'(mem_addr[7:0] + 8'd2)] <= mem_wdata[23:16];
        mem[8'(mem_addr[7:0] + 8'd3)] <= mem_wdata[31:24];
      end
    end
  end

  // Expectation for the single outstanding request, in cycle numbers.
  int e_acc = -100, e_s1 = -100, e_rv = -100;
  logic e_rd = 1'b0, e_wr = 1'b0, e_mis = 1'b0, e_tmo = 1'b0;
  logic [31:0] e_addr = '0, e_wd = '0, e_rdata = '0;
  logic [2:0]  e_mask = '0;
  int m_ld = 0, m_st = 0, m_f = 0;

  int vecs = 0, errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      logic rv, busy, strb;
      rv   = (cyc == e_rv);
      busy = (cyc >= e_acc) && (cyc < e_rv);
      strb = (cyc >= e_acc) && (cyc < e_s1);
      chk("resp_valid", 32'(resp_valid), 32'(rv));
      chk("stall", 32'(stall), 32'(busy));
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("mem_read", 32'(mem_read), 32'(strb && e_rd));
      chk("mem_write", 32'(mem_write), 32'(strb && e_wr));
      if (strb) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_mask", 32'(mem_mask), 32'(e_mask));
        if (e_wr) chk("mem_wdata", mem_wdata, e_wd);
      end
      if (rv) begin
        chk("resp_rdata", resp_rdata, e_rdata);
        chk("fault_misaligned", 32'(fault_misaligned), 32'(e_mis));
        chk("fault_timeout", 32'(fault_timeout), 32'(e_tmo));
        chk("load_count", 32'(load_count), 32'(m_ld));
        chk("store_count", 32'(store_count), 32'(m_st));
        chk("fault_count", 32'(fault_count), 32'(m_f));
      end
    end
  end

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] m, input int hl);
    int guard;
    logic ill;
    guard = 0;
    @(negedge clk); #2;
    while (cyc < e_rv) begin
      @(negedge clk); #2;
      guard++;
      if (guard > 50) begin
        vecs++; errs++;
        $display("FAIL wait_idle cyc=%0d got=busy want=idle", cyc);
        return;
      end
    end
    ill = (rd && wr) || (m inside {3'b011, 3'b110, 3'b111}) ||
          (wr && (m inside {3'b100, 3'b101})) ||
          ((m inside {3'b001, 3'b101}) && a[0]) ||
          ((m == 3'b010) && (a[1:0] != 2'b00));
    e_acc = cyc + 1;
    acc = cyc + 1;
    hit_lat = hl;
    e_addr = a; e_wd = wd; e_mask = m;
    e_rd = rd && !ill;
    e_wr = wr && !ill;
    if (ill) begin
      e_s1 = e_acc; e_rv = e_acc + 1;
      e_rdata = '0; e_mis = 1'b1; e_tmo = 1'b0; m_f = sat(m_f);
    end else if (hl <= T) begin
      e_s1 = e_acc + hl; e_rv = e_acc + hl + 1;
      e_rdata = rd ? ld(a, m) : 32'h0; e_mis = 1'b0; e_tmo = 1'b0;
      if (rd) m_ld = sat(m_ld); else m_st = sat(m_st);
    end else begin
      e_s1 = e_acc + T; e_rv = e_acc + T + 1;
      e_rdata = '0; e_mis = 1'b0; e_tmo = 1'b1; m_f = sat(m_f);
    end
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_addr = a; req_wdata = wd; req_mask = m;
    @(posedge clk); #1;
    // Scramble the request bus to show the in-flight access ignores it.
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_read  = 1'($urandom);
    req_write = 1'($urandom);
    req_mask  = 3'($urandom);
  endtask

  task automatic settle();
    while (cyc <= e_rv) @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hEF; mem[8'h11] = 8'hBE; mem[8'h12] = 8'hAD; mem[8'h13] = 8'hDE;

    repeat (3) @(negedge clk);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_counts", 32'({load_count, store_count, fault_count}), 32'h0);
    #2 reset = 1'b0;

    req(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1);
    settle();
    chk("lit_lw_rdata", resp_rdata, 32'hDEADBEEF);
    chk("lit_lw_count", 32'(load_count), 32'h1);

    req(1'b0, 1'b1, 32'h22, 32'h0000ABCD, 3'b001, 1);
    settle();
    chk("lit_sh_rdata", resp_rdata, 32'h0);
    chk("lit_sh_count", 32'(store_count), 32'h1);

    req(1'b1, 1'b0, 32'h22, 32'h0, 3'b101, 1);
    settle();
    chk("lit_lhu_rdata", resp_rdata, 32'h0000ABCD);

    req(1'b1, 1'b0, 32'h13, 32'h0, 3'b010, 1);
    req(1'b0, 1'b1, 32'h21, 32'h1234, 3'b001, 1);
    settle();
    chk("lit_mis_flag", 32'(fault_misaligned), 32'h1);
    chk("lit_mis_count", 32'(fault_count), 32'h2);

    req(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 100);
    settle();
    chk("lit_tmo_flag", 32'(fault_timeout), 32'h1);
    chk("lit_tmo_count", 32'(fault_count), 32'h3);

    req(1'b1, 1'b1, 32'h10, 32'h0, 3'b010, 1);
    req(1'b1, 1'b0, 32'h10, 32'h0, 3'b111, 1);
    settle();
    chk("lit_ill_count", 32'(fault_count), 32'h5);

    @(negedge clk); #2;
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("noop_req_ready", 32'(req_ready), 32'h1);
    end
    req_valid = 1'b0;

    for (int n = 0; n < 80; n++) begin
      logic rd, wr;
      logic [2:0] m;
      logic [31:0] a;
      int sel;
      sel = int'($urandom_range(0, 9));
      rd = (sel < 5) || (sel == 9);
      wr = (sel >= 5);
      m  = 3'($urandom);
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (m == 3'b010) a[1:0] = 2'b00;
        if (m inside {3'b001, 3'b101}) a[0] = 1'b0;
      end
      req(rd, wr, a, $urandom, m, int'($urandom_range(1, 6)));
    end
    settle();

    // Abort an in-flight load with reset; nothing may complete for it.
    req(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 100);
    @(negedge clk); #2;
    e_acc = -100; e_s1 = -100; e_rv = -100;
    m_ld = 0; m_st = 0; m_f = 0;
    reset = 1'b1;
    #1;
    chk("arst_mem_read", 32'(mem_read), 32'h0);
    chk("arst_stall", 32'(stall), 32'h0);
    chk("arst_counts", 32'({load_count, store_count, fault_count}), 32'h0);
    @(negedge clk); #2 reset = 1'b0;

    req(1'b1, 1'b0, 32'h44, 32'h0, 3'b000, 1);
    settle();
    chk("lit_post_rst_count", 32'(load_count), 32'h1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end
endmodule
